row_coef_collector: RTL

//  Downstream neighbour of the row-level CDF 5/3 processor. Captures the per-pair
//  (s, d) coefficient stream and places it into one output row.

---
 rtl/row_coef_collector.sv | 92 +++++++++
 1 files changed

// File: rtl/row_coef_collector.sv
// Collects the (s, d) coefficient pairs of one row from the row processor into a single row
// (lowpass in the first half, highpass in the second) and offers it with a valid/ready handshake.
module row_coef_collector #(
  parameter int unsigned LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             s_in,
  input  logic [7:0]             d_in,
  input  logic                   coef_valid,
  output logic [LENGTH-1:0][7:0] out_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned HALF  = LENGTH / 2;
  localparam int unsigned IDX_W = $clog2(HALF) + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LENGTH-1:0][7:0] row_q, row_d;
  logic                   err_q, err_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COLLECT;
          idx_d   = '0;
        end
        // A pair with no open row is dropped, even alongside start.
        if (coef_valid) err_d = 1'b1;
      end
      ST_COLLECT: begin
        if (start) begin
          idx_d = '0;
          err_d = 1'b1;
        end else if (coef_valid) begin
          for (int unsigned i = 0; i < HALF; i++) begin
            if (idx_q == IDX_W'(i)) begin
              row_d[i]        = s_in;
              row_d[HALF + i] = d_in;
            end
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(HALF - 1)) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (coef_valid) err_d = 1'b1;
        if (out_ready) begin
          state_d = start ? ST_COLLECT : ST_IDLE;
          idx_d   = '0;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  assign out_row   = row_q;
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule
